// File: rtl/mdl_pgcmp_if.sv
// Page-compare signal bundle: clock enable and page shift register serial stream in,
// loop position and compare status out.
interface mdl_pgcmp_if #(
  parameter int PG_WIDTH = 12
);
  logic                i_CLK2M_PCEN_n;
  logic                i_PGREG_SR_SHIFT;
  logic                i_PGREG_SR_LSB;
  logic                i_POS_ADV;
  logic                i_POS_CLR;
  logic [PG_WIDTH-1:0] o_POS;
  logic                o_POS_WRAP;
  logic                o_PGCMP_BUSY;
  logic                o_PGCMP_DONE;
  logic                o_PGCMP_MATCH;

  // Driver side: page register and bubble timing feed this block.
  modport master (
    output i_CLK2M_PCEN_n, i_PGREG_SR_SHIFT, i_PGREG_SR_LSB, i_POS_ADV, i_POS_CLR,
    input  o_POS, o_POS_WRAP, o_PGCMP_BUSY, o_PGCMP_DONE, o_PGCMP_MATCH
  );

  // Comparator side.
  modport slave (
    input  i_CLK2M_PCEN_n, i_PGREG_SR_SHIFT, i_PGREG_SR_LSB, i_POS_ADV, i_POS_CLR,
    output o_POS, o_POS_WRAP, o_PGCMP_BUSY, o_PGCMP_DONE, o_PGCMP_MATCH
  );
endinterface

// File: rtl/mdl_pgcmp.sv
// Bubble-loop position counter plus bit-serial page comparator. The position is
// snapshotted when a page window starts and compared LSB first against the page
// shift register stream; MATCH/DONE tell the sequencer when to start the transfer.
// Every state update is gated by the 2 MHz clock enable; reset is synchronous.
module mdl_pgcmp #(
  parameter int PG_WIDTH = 12,
  parameter int LOOP_LEN = 2053
) (
  input  logic      i_MCLK,
  input  logic      i_SYS_RST,
  mdl_pgcmp_if.slave pg
);

  localparam int                  CNT_W    = $clog2(PG_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PG_WIDTH - 1);
  localparam logic [PG_WIDTH-1:0] POS_LAST = PG_WIDTH'(LOOP_LEN - 1);
  localparam logic [PG_WIDTH-1:0] POS_ONE  = PG_WIDTH'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  logic                en;
  logic [PG_WIDTH-1:0] pos_q;
  logic                wrap_q;
  logic [1:0]          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mism_q;
  logic                done_q;
  logic                match_q;
  logic                shift_prev_q;
  logic [PG_WIDTH-1:0] snap_q;
  logic                start;

  assign en = ~pg.i_CLK2M_PCEN_n;

  // A window only opens on a rising SHIFT: a stream that stays high past its
  // last bit must not be taken as the start of a second page.
  assign start = (state_q == ST_IDLE) && pg.i_PGREG_SR_SHIFT && !shift_prev_q;

  // Loop position: clear wins over advance; wrap pulse lasts one enable period.
  always_ff @(posedge i_MCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_SYS_RST) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else if (en) begin
      wrap_q <= 1'b0;
      if (pg.i_POS_CLR) begin
        pos_q <= '0;
      end else if (pg.i_POS_ADV) begin
        if (pos_q == POS_LAST) begin
          pos_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          pos_q <= pos_q + POS_ONE;
        end
      end
    end
  end

  // Position snapshot taken as a window opens; the compare never sees later moves.
  always_ff @(posedge i_MCLK) begin
    // NOTE: the snapshot has no reset; it is written on window start before any read.
    if (en && start) begin
      snap_q <= pos_q;
    end
  end

  // Compare FSM: IDLE -> SHIFT (PG_WIDTH bits) -> RESULT (one enable) -> IDLE.
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mism_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      shift_prev_q <= 1'b0;
    end else if (en) begin
      done_q       <= 1'b0;
      shift_prev_q <= pg.i_PGREG_SR_SHIFT;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mism_q  <= pg.i_PGREG_SR_LSB ^ pos_q[0];
            cnt_q   <= CNT_W'(1);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!pg.i_PGREG_SR_SHIFT) begin
            // Window broken off early: drop it, keep the last reported result.
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            mism_q <= mism_q | (pg.i_PGREG_SR_LSB ^ snap_q[cnt_q]);
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_RESULT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RESULT: begin
          done_q  <= 1'b1;
          match_q <= ~mism_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pg.o_POS         = pos_q;
  assign pg.o_POS_WRAP    = wrap_q;
  assign pg.o_PGCMP_BUSY  = (state_q != ST_IDLE);
  assign pg.o_PGCMP_DONE  = done_q;
  assign pg.o_PGCMP_MATCH = match_q;

endmodule

// File: tb/tb_mdl_pgcmp.sv
// Directed bench for mdl_pgcmp: position counting and wrap, page compare match and
// mismatch, position moves during a window, aborted and over-long windows, reset mid-window.
module tb_mdl_pgcmp;

  logic i_MCLK = 1'b0;
  logic i_SYS_RST;
  int   n_checks = 0;
  int   n_errors = 0;

  mdl_pgcmp_if #(.PG_WIDTH(12)) pg ();

  mdl_pgcmp #(.PG_WIDTH(12), .LOOP_LEN(2053)) dut (
    .i_MCLK   (i_MCLK),
    .i_SYS_RST(i_SYS_RST),
    .pg       (pg)
  );

  always #5 i_MCLK = ~i_MCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One enabled clock edge with the given inputs; outputs are read 1 ns after it.
  task automatic step(input logic sh, input logic lsb, input logic adv, input logic clr);
    @(negedge i_MCLK);
    pg.i_CLK2M_PCEN_n   = 1'b0;
    pg.i_PGREG_SR_SHIFT = sh;
    pg.i_PGREG_SR_LSB   = lsb;
    pg.i_POS_ADV        = adv;
    pg.i_POS_CLR        = clr;
    @(posedge i_MCLK);
    #1;
  endtask

  // One clock edge with the enable inactive but busy-looking inputs.
  task automatic idle_edge();
    @(negedge i_MCLK);
    pg.i_CLK2M_PCEN_n   = 1'b1;
    pg.i_PGREG_SR_SHIFT = 1'b1;
    pg.i_PGREG_SR_LSB   = 1'b1;
    pg.i_POS_ADV        = 1'b1;
    pg.i_POS_CLR        = 1'b1;
    @(posedge i_MCLK);
    #1;
  endtask

  task automatic set_pos(input int v);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (v) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Shifts a 12-bit page LSB first, then one enable with SHIFT low for the result.
  // busy_bits/done_bits record BUSY and DONE after each of the 13 enables.
  task automatic run_window(input logic [11:0] val, input logic adv,
                            output logic [12:0] busy_bits, output logic [12:0] done_bits);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, val[i], adv, 1'b0);
      busy_bits[i] = pg.o_PGCMP_BUSY;
      done_bits[i] = pg.o_PGCMP_DONE;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    busy_bits[12] = pg.o_PGCMP_BUSY;
    done_bits[12] = pg.o_PGCMP_DONE;
  endtask

  initial begin : stim
    logic [12:0]      busy_bits;
    logic [12:0]      done_bits;
    logic [11:0]      pos_exp;
    logic             pos_ok;
    int               wraps;
    int               dones;

    pg.i_CLK2M_PCEN_n   = 1'b1;
    pg.i_PGREG_SR_SHIFT = 1'b0;
    pg.i_PGREG_SR_LSB   = 1'b0;
    pg.i_POS_ADV        = 1'b0;
    pg.i_POS_CLR        = 1'b0;
    i_SYS_RST           = 1'b1;
    repeat (2) @(posedge i_MCLK);
    #1;
    check("rst_pos",   pg.o_POS,          32'h0);
    check("rst_wrap",  pg.o_POS_WRAP,     32'h0);
    check("rst_busy",  pg.o_PGCMP_BUSY,   32'h0);
    check("rst_done",  pg.o_PGCMP_DONE,   32'h0);
    check("rst_match", pg.o_PGCMP_MATCH,  32'h0);
    @(negedge i_MCLK);
    i_SYS_RST = 1'b0;

    // T1: full loop walk, single wrap pulse, CLR beats ADV.
    wraps  = 0;
    pos_ok = 1'b1;
    for (int i = 1; i <= 2053; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      pos_exp = (i == 2053) ? 12'd0 : 12'(i);
      if (pg.o_POS !== pos_exp) pos_ok = 1'b0;
      if (pg.o_POS_WRAP === 1'b1) wraps++;
      if (i == 2052) check("t1_pos_last", pg.o_POS, 32'd2052);
      if (i == 2053) check("t1_wrap_pulse", pg.o_POS_WRAP, 32'h1);
    end
    check("t1_pos_walk", pos_ok, 32'h1);
    check("t1_wrap_count", wraps, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_pos_after_wrap", pg.o_POS, 32'd1);
    check("t1_wrap_cleared", pg.o_POS_WRAP, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_clr_adv_pos", pg.o_POS, 32'd0);
    check("t1_clr_adv_wrap", pg.o_POS_WRAP, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_edge();
    check("t1_hold_no_enable", pg.o_POS, 32'd2);

    // T2: matching page, 13-enable window, DONE held between enables.
    set_pos(12'h2A5);
    check("t2_pos", pg.o_POS, 32'h2A5);
    run_window(12'h2A5, 1'b0, busy_bits, done_bits);
    check("t2_busy", busy_bits, 32'h0FFF);
    check("t2_done", done_bits, 32'h1000);
    check("t2_match", pg.o_PGCMP_MATCH, 32'h1);
    idle_edge();
    check("t2_done_held", pg.o_PGCMP_DONE, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_done_end", pg.o_PGCMP_DONE, 32'h0);
    check("t2_match_held", pg.o_PGCMP_MATCH, 32'h1);

    // T3: one-bit mismatch in bit 0, then a match again.
    run_window(12'h2A4, 1'b0, busy_bits, done_bits);
    check("t3_done_a", done_bits, 32'h1000);
    check("t3_mismatch", pg.o_PGCMP_MATCH, 32'h0);
    run_window(12'h2A5, 1'b0, busy_bits, done_bits);
    check("t3_done_b", done_bits, 32'h1000);
    check("t3_match", pg.o_PGCMP_MATCH, 32'h1);

    // T4: position advances every bit enable; the compare uses the start snapshot.
    set_pos(12'h100);
    run_window(12'h100, 1'b1, busy_bits, done_bits);
    check("t4_done", done_bits, 32'h1000);
    check("t4_match", pg.o_PGCMP_MATCH, 32'h1);
    check("t4_pos", pg.o_POS, 32'h10C);

    // T5: abort after 5 bits keeps MATCH; then SHIFT held 20 enables gives one DONE.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_busy_mid", pg.o_PGCMP_BUSY, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_abort_busy", pg.o_PGCMP_BUSY, 32'h0);
    check("t5_abort_done", pg.o_PGCMP_DONE, 32'h0);
    check("t5_abort_match", pg.o_PGCMP_MATCH, 32'h1);
    pos_exp = 12'h10C;
    dones   = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i < 12) ? pos_exp[i] : 1'b0, 1'b0, 1'b0);
      if (pg.o_PGCMP_DONE === 1'b1) dones++;
    end
    check("t5_long_done_count", dones, 32'd1);
    check("t5_long_match", pg.o_PGCMP_MATCH, 32'h1);
    check("t5_long_no_restart", pg.o_PGCMP_BUSY, 32'h0);

    // T6: reset at bit 7 of a window with the enable active.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, pos_exp[i], 1'b0, 1'b0);
    check("t6_busy_before", pg.o_PGCMP_BUSY, 32'h1);
    @(negedge i_MCLK);
    i_SYS_RST           = 1'b1;
    pg.i_CLK2M_PCEN_n   = 1'b0;
    pg.i_PGREG_SR_SHIFT = 1'b1;
    pg.i_PGREG_SR_LSB   = pos_exp[7];
    @(posedge i_MCLK);
    #1;
    check("t6_rst_pos",   pg.o_POS,         32'h0);
    check("t6_rst_busy",  pg.o_PGCMP_BUSY,  32'h0);
    check("t6_rst_done",  pg.o_PGCMP_DONE,  32'h0);
    check("t6_rst_match", pg.o_PGCMP_MATCH, 32'h0);
    check("t6_rst_wrap",  pg.o_POS_WRAP,    32'h0);
    @(negedge i_MCLK);
    i_SYS_RST = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_no_done_after", pg.o_PGCMP_DONE, 32'h0);
    run_window(12'h000, 1'b0, busy_bits, done_bits);
    check("t6_clean_busy", busy_bits, 32'h0FFF);
    check("t6_clean_done", done_bits, 32'h1000);
    check("t6_clean_match", pg.o_PGCMP_MATCH, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
